// File: rtl/kw_ram_1ra_1ws_arb.sv
// Round-robin access controller for the async-read / sync-write flip-flop RAM.
// Shares one RAM write port and one RAM read port between NUM_REQ requesters,
// registers read data one cycle after the grant, and optionally zero-fills
// every word after reset so the RAM itself can be built without a reset.
//
// Handshake: a transfer on requester i happens in any cycle where
// valid[i] & ready[i] are both high. ready is a pure function of the valid
// vector, the arbitration pointer and the FSM state (never of ready itself).
// A requester must hold valid/addr/data stable until it sees ready.
// rsp_valid is a one-cycle pulse with no back-pressure.
//
// init_done is the decoded FSM state register (high only in RUN), which also
// serves as the state observation point for the controller.
module kw_ram_1ra_1ws_arb #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int INIT_ZERO  = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               wr_valid,
    output logic [NUM_REQ-1:0]               wr_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_REQ-1:0]               rd_valid,
    output logic [NUM_REQ-1:0]               rd_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             init_done,
    output logic                             ram_cs_n,
    output logic                             ram_we_n,
    output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
    output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
    output logic [DATA_WIDTH-1:0]            ram_data_in,
    input  logic [DATA_WIDTH-1:0]            ram_data_out
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fill_q, fill_d;
    logic                   fill_active;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W-1:0]       wr_idx, rd_idx;
    logic                   wr_any, rd_any;
    logic [NUM_REQ-1:0]     wr_gnt, rd_gnt;

    // First requesting index at or after ptr, wrapping; returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
        logic [SUM_W-1:0] cand;
        logic             found;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
            if (!found && req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[PTR_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Pointer moves to the requester just after the one granted.
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
        return (idx == PTR_LAST) ? '0 : idx + 1'b1;
    endfunction

    // FSM state and fill counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Next state: INIT walks the fill counter (or leaves at once), RUN is terminal.
    // The fill write is suppressed while reset is held so the RAM stays idle.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        fill_active = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_ZERO != 0) begin
                    fill_active = !reset;
                    if (fill_q == FILL_LAST) state_d = ST_RUN;
                    else                     fill_d  = fill_q + 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign init_done = (state_q == ST_RUN);

    // Independent round-robin selection for the write and read ports, RUN only.
    always_comb begin
        {wr_any, wr_idx} = '0;
        {rd_any, rd_idx} = '0;
        if (state_q == ST_RUN) begin
            {wr_any, wr_idx} = rr_pick(wr_valid, wptr_q);
            {rd_any, rd_idx} = rr_pick(rd_valid, rptr_q);
        end
        wr_gnt = wr_any ? (NUM_REQ'(1) << wr_idx) : '0;
        rd_gnt = rd_any ? (NUM_REQ'(1) << rd_idx) : '0;
        wptr_d = wr_any ? rr_next(wr_idx) : wptr_q;
        rptr_d = rd_any ? rr_next(rd_idx) : rptr_q;
    end

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;

    // Arbitration pointers; requester 0 has first priority out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // RAM port drive straight from the fill sequencer or the current grants.
    always_comb begin
        ram_cs_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_wr_addr = '0;
        ram_data_in = '0;
        ram_rd_addr = '0;
        if (fill_active) begin
            ram_cs_n    = 1'b0;
            ram_we_n    = 1'b0;
            ram_wr_addr = fill_q;
        end else if (wr_any) begin
            ram_cs_n    = 1'b0;
            ram_we_n    = 1'b0;
            ram_wr_addr = wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data_in = wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rd_any) begin
            ram_rd_addr = rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Read response: capture the async RAM output at the end of a grant cycle.
    // No forwarding, so a same-cycle write to the read address returns the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_gnt;
            if (rd_any) rsp_data <= ram_data_out;
        end
    end

endmodule

// File: tb/tb_kw_ram_1ra_1ws_arb.sv
// Directed bench for kw_ram_1ra_1ws_arb: NUM_REQ=2, DEPTH=16, DATA_WIDTH=8.
// dut_a uses INIT_ZERO=1 with a behavioural RAM; dut_b uses INIT_ZERO=0.
module tb_kw_ram_1ra_1ws_arb;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic clock = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // dut_a signals
    logic             reset;
    logic [NR-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
    logic [NR*AW-1:0] wr_addr, rd_addr;
    logic [NR*DW-1:0] wr_data;
    logic [DW-1:0]    rsp_data, ram_data_in, ram_data_out;
    logic             init_done, ram_cs_n, ram_we_n;
    logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [DW-1:0]    mem [0:DP-1];

    // dut_b signals
    logic             b_reset;
    logic [NR-1:0]    b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_rsp_valid;
    logic [NR*AW-1:0] b_wr_addr, b_rd_addr;
    logic [NR*DW-1:0] b_wr_data;
    logic [DW-1:0]    b_rsp_data, b_ram_data_in, b_ram_data_out;
    logic             b_init_done, b_ram_cs_n, b_ram_we_n;
    logic [AW-1:0]    b_ram_wr_addr, b_ram_rd_addr;

    always #5 clock = ~clock;

    kw_ram_1ra_1ws_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP), .INIT_ZERO(1)) dut_a (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_wr_addr(ram_wr_addr),
        .ram_rd_addr(ram_rd_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    kw_ram_1ra_1ws_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP), .INIT_ZERO(0)) dut_b (
        .clock(clock), .reset(b_reset),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .init_done(b_init_done),
        .ram_cs_n(b_ram_cs_n), .ram_we_n(b_ram_we_n), .ram_wr_addr(b_ram_wr_addr),
        .ram_rd_addr(b_ram_rd_addr), .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out)
    );

    // Behavioural async-read / sync-write RAM behind dut_a.
    always @(posedge clock) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_wr_addr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_rd_addr];

    // Inputs change 1 time unit after the rising edge; checks run 3 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        wr_valid = 2'b11; rd_valid = 2'b11;
        wr_addr = 8'h21; rd_addr = 8'h43; wr_data = 16'hBEEF;
        repeat (3) tick();
        #3;
        n_checks++;
        if ({wr_ready, rd_ready, rsp_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 000000", {wr_ready, rd_ready, rsp_valid});
        end
        n_checks++;
        if (rsp_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data);
        end
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done);
        end
        n_checks++;
        if ({ram_cs_n, ram_we_n} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ram_ctl: got %b expected 11", {ram_cs_n, ram_we_n});
        end
    endtask

    task automatic test_fill();
        for (int c = 0; c < DP; c++) begin
            tick();
            reset = 1'b0;
            #3;
            n_checks++;
            if ({ram_cs_n, ram_we_n, ram_wr_addr, ram_data_in} !== {2'b00, AW'(c), 8'h00}) begin
                n_fail++; $display("FAIL fill_write c=%0d: got cs/we=%b addr=%0d data=%h expected 00/%0d/00",
                                   c, {ram_cs_n, ram_we_n}, ram_wr_addr, ram_data_in, c);
            end
            n_checks++;
            if ({wr_ready, rd_ready, init_done} !== 5'b0) begin
                n_fail++; $display("FAIL fill_idle c=%0d: got ready/done=%b expected 00000", c, {wr_ready, rd_ready, init_done});
            end
        end
        tick();
        wr_valid = 2'b00; rd_valid = 2'b00;
        #3;
        n_checks++;
        if ({init_done, ram_we_n} !== 2'b11) begin
            n_fail++; $display("FAIL fill_done: got done/we_n=%b expected 11", {init_done, ram_we_n});
        end
        // Requester 1 reads address 5, which was 0xFF before the fill.
        tick();
        rd_valid = 2'b10; rd_addr = {4'd5, 4'd0};
        #3;
        n_checks++;
        if ({rd_ready, ram_rd_addr} !== {2'b10, 4'd5}) begin
            n_fail++; $display("FAIL fill_rd_grant: got ready=%b addr=%0d expected 10/5", rd_ready, ram_rd_addr);
        end
        tick();
        rd_valid = 2'b00;
        #3;
        n_checks++;
        if ({rsp_valid, rsp_data} !== {2'b10, 8'h00}) begin
            n_fail++; $display("FAIL fill_rd_data: got valid=%b data=%h expected 10/00", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_write_rr();
        logic [NR-1:0] exp_gnt [4];
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        for (int c = 0; c < 4; c++) begin
            tick();
            wr_valid = 2'b11; wr_addr = {4'd4, 4'd3}; wr_data = {8'h5A, 8'hA5};
            #3;
            n_checks++;
            if (wr_ready !== exp_gnt[c]) begin
                n_fail++; $display("FAIL wr_rr_grant c=%0d: got %b expected %b", c, wr_ready, exp_gnt[c]);
            end
            n_checks++;
            if ({ram_we_n, ram_wr_addr, ram_data_in} !==
                ((exp_gnt[c] == 2'b01) ? {1'b0, 4'd3, 8'hA5} : {1'b0, 4'd4, 8'h5A})) begin
                n_fail++; $display("FAIL wr_rr_ram c=%0d: got we_n=%b addr=%0d data=%h", c, ram_we_n, ram_wr_addr, ram_data_in);
            end
        end
        tick();
        wr_valid = 2'b00;
        #3;
        n_checks++;
        if ({ram_cs_n, ram_we_n, wr_ready} !== 4'b1100) begin
            n_fail++; $display("FAIL wr_rr_idle: got %b expected 1100", {ram_cs_n, ram_we_n, wr_ready});
        end
    endtask

    task automatic test_back_to_back();
        tick();
        rd_valid = 2'b11; rd_addr = {4'd4, 4'd3};
        #3;
        n_checks++;
        if (rd_ready !== 2'b01) begin
            n_fail++; $display("FAIL b2b_grant_n: got %b expected 01", rd_ready);
        end
        tick();
        #3;
        n_checks++;
        if ({rd_ready, rsp_valid, rsp_data} !== {2'b10, 2'b01, 8'hA5}) begin
            n_fail++; $display("FAIL b2b_n1: got ready=%b valid=%b data=%h expected 10/01/a5", rd_ready, rsp_valid, rsp_data);
        end
        tick();
        rd_valid = 2'b00;
        #3;
        n_checks++;
        if ({rd_ready, rsp_valid, rsp_data} !== {2'b00, 2'b10, 8'h5A}) begin
            n_fail++; $display("FAIL b2b_n2: got ready=%b valid=%b data=%h expected 00/10/5a", rd_ready, rsp_valid, rsp_data);
        end
        tick();
        #3;
        n_checks++;
        if ({rsp_valid, rsp_data} !== {2'b00, 8'h5A}) begin
            n_fail++; $display("FAIL b2b_hold: got valid=%b data=%h expected 00/5a", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_hazard();
        tick();
        wr_valid = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {8'h00, 8'h11};
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd7};
        #3;
        n_checks++;
        if ({wr_ready, rd_ready} !== 4'b0101) begin
            n_fail++; $display("FAIL hazard_grant: got %b expected 0101", {wr_ready, rd_ready});
        end
        tick();
        wr_valid = 2'b00;
        #3;
        n_checks++;
        if ({rd_ready, rsp_valid, rsp_data} !== {2'b01, 2'b01, 8'h00}) begin
            n_fail++; $display("FAIL hazard_old: got ready=%b valid=%b data=%h expected 01/01/00", rd_ready, rsp_valid, rsp_data);
        end
        tick();
        rd_valid = 2'b00;
        #3;
        n_checks++;
        if ({rsp_valid, rsp_data} !== {2'b01, 8'h11}) begin
            n_fail++; $display("FAIL hazard_new: got valid=%b data=%h expected 01/11", rsp_valid, rsp_data);
        end
    endtask

    // Reset lands in a read-grant cycle; the response must be dropped.
    task automatic test_reset_drop();
        tick();
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd3}; reset = 1'b1;
        #3;
        n_checks++;
        if (rd_ready !== 2'b01) begin
            n_fail++; $display("FAIL drop_grant: got %b expected 01", rd_ready);
        end
        tick();
        reset = 1'b0; rd_valid = 2'b00;
        #3;
        n_checks++;
        if ({rsp_valid, rsp_data, init_done} !== {2'b00, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL drop_rsp: got valid=%b data=%h done=%b expected 00/00/0", rsp_valid, rsp_data, init_done);
        end
        n_checks++;
        if ({ram_we_n, ram_wr_addr} !== {1'b0, 4'd0}) begin
            n_fail++; $display("FAIL drop_fill0: got we_n=%b addr=%0d expected 0/0", ram_we_n, ram_wr_addr);
        end
    endtask

    // Continues the fill started above, pulses reset at fill cycle 8.
    task automatic test_reset_mid_fill();
        for (int c = 1; c < 8; c++) begin
            tick();
            #3;
            n_checks++;
            if ({ram_we_n, ram_wr_addr} !== {1'b0, AW'(c)}) begin
                n_fail++; $display("FAIL mid_pre c=%0d: got we_n=%b addr=%0d", c, ram_we_n, ram_wr_addr);
            end
        end
        tick();
        reset = 1'b1;
        #3;
        n_checks++;
        if ({ram_cs_n, ram_we_n} !== 2'b11) begin
            n_fail++; $display("FAIL mid_reset_idle: got %b expected 11", {ram_cs_n, ram_we_n});
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < DP; c++) begin
            if (c != 0) tick();
            #3;
            n_checks++;
            if ({ram_we_n, ram_wr_addr, init_done} !== {1'b0, AW'(c), 1'b0}) begin
                n_fail++; $display("FAIL mid_refill c=%0d: got we_n=%b addr=%0d done=%b", c, ram_we_n, ram_wr_addr, init_done);
            end
        end
        tick();
        #3;
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++; $display("FAIL mid_done: got %b expected 1", init_done);
        end
    endtask

    task automatic test_no_init();
        tick();
        b_reset = 1'b0;
        b_wr_valid = 2'b01; b_wr_addr = {4'd0, 4'd9}; b_wr_data = {8'h00, 8'h77};
        #3;
        n_checks++;
        if ({b_init_done, b_wr_ready, b_ram_we_n} !== {1'b0, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL noinit_c0: got done=%b ready=%b we_n=%b expected 0/00/1", b_init_done, b_wr_ready, b_ram_we_n);
        end
        tick();
        #3;
        n_checks++;
        if ({b_init_done, b_wr_ready, b_ram_we_n, b_ram_wr_addr, b_ram_data_in} !==
            {1'b1, 2'b01, 1'b0, 4'd9, 8'h77}) begin
            n_fail++; $display("FAIL noinit_c1: got done=%b ready=%b we_n=%b addr=%0d data=%h expected 1/01/0/9/77",
                               b_init_done, b_wr_ready, b_ram_we_n, b_ram_wr_addr, b_ram_data_in);
        end
        b_wr_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            #3;
            n_checks++;
            if ({b_ram_cs_n, b_ram_we_n, b_ram_wr_addr} !== {2'b11, 4'd0}) begin
                n_fail++; $display("FAIL noinit_idle c=%0d: got cs/we=%b addr=%0d expected 11/0", c, {b_ram_cs_n, b_ram_we_n}, b_ram_wr_addr);
            end
        end
    endtask

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        b_wr_valid = '0; b_rd_valid = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
        b_ram_data_out = 8'h00;
        for (int i = 0; i < DP; i++) mem[i] = 8'hFF;

        test_reset();
        test_fill();
        test_write_rr();
        test_back_to_back();
        test_hazard();
        test_reset_drop();
        test_reset_mid_fill();
        test_no_init();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kw_ram_1ra_1ws_arb.md
# kw_ram_1ra_1ws_arb

Round-robin access controller for the async-read / sync-write flip-flop RAM. It shares the RAM's single write port and single read port between NUM_REQ requesters using valid/ready handshakes, and returns read data registered one cycle later. It also contains an optional post-reset zero-fill sequencer, so the RAM can be built non-resettable (its reset_n tied high). It sits between the requesting engines and the RAM instance, and drives every RAM input directly.

## Interface
- NUM_REQ, 2: number of requesters per port; range 2-8.
- DATA_WIDTH, 32: RAM word width; range 1-256.
- DEPTH, 16: RAM words; range 2-256.
- INIT_ZERO, 1: 1 = zero-fill all words after reset; 0 = skip fill.
- ADDR_WIDTH, $clog2(DEPTH): derived; do not override.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  NUM_REQ  write request per requester.
- wr_ready  out  NUM_REQ  write grant; a transfer occurs when wr_valid[i] & wr_ready[i].
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i at slice i.
- wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- rd_valid  in  NUM_REQ  read request.
- rd_ready  out  NUM_REQ  read grant.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- rsp_valid  out  NUM_REQ  one-cycle pulse to the requester whose read completed.
- rsp_data  out  DATA_WIDTH  registered read data, shared by all requesters.
- init_done  out  1  high once the controller is in RUN.
- ram_cs_n, ram_we_n  out  1 each  RAM chip select and write enable, both active low.
- ram_wr_addr, ram_rd_addr  out  ADDR_WIDTH  RAM addresses.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM asynchronous read data.

## Operation
- States: INIT and RUN. Reset forces INIT with fill counter = 0.
  - INIT with INIT_ZERO=1: write 0 to address counter each cycle; after address DEPTH-1, go to RUN.
  - INIT with INIT_ZERO=0: go to RUN on the first cycle after reset.
  - RUN has no exit except reset.
- In INIT: all wr_ready and rd_ready are 0, and requests are ignored.
- Write arbitration, RUN only:
  - Round-robin pointer wptr; the search starts at wptr.
  - The first i with wr_valid[i] gets wr_ready[i]=1. At most one ready bit is high per cycle.
  - On a grant to i: wptr <= (i+1) mod NUM_REQ.
  - With no requests, wptr holds.
- Read arbitration: identical scheme with an independent pointer rptr. One read and one write can both be granted in the same cycle.
- RAM drive, combinational from the grant:
  - Write grant (or an INIT fill cycle): ram_cs_n=0, ram_we_n=0, ram_wr_addr/ram_data_in = granted slice (fill: counter/0).
  - Otherwise: ram_cs_n=ram_we_n=1, ram_wr_addr=0, ram_data_in=0.
  - ram_rd_addr = granted read slice, else 0.
- Read response: on the edge that ends a read-grant cycle:
  - rsp_data <= ram_data_out.
  - rsp_valid <= one-hot of the granted index.
  - There is no response back-pressure.
- Read/write hazard:
  - Same address in the same cycle: the read returns the old word.
  - A read granted in the cycle after the write returns the new word.
  - The controller performs no forwarding.
- Grant logic depends on valid only, never on ready.

## Timing
- Reset values: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, ram_cs_n=1, ram_we_n=1, wptr=rptr=0 (requester 0 has highest priority first).
- init_done rises DEPTH cycles after reset deasserts (INIT_ZERO=1), or 1 cycle after (INIT_ZERO=0). It is registered.
- Read latency: grant cycle N gives rsp_valid/rsp_data in cycle N+1. rsp_data holds until the next response.
- Throughput: 1 write + 1 read per cycle. Each active requester is served at least once every NUM_REQ grants.
- Reset asserted mid-fill: the fill restarts from address 0. Any in-flight response is dropped (rsp_valid=0 next cycle).
- Combinational paths wr_valid/addr/data -> ram_* and rd_valid -> wr_ready/rd_ready are allowed. No path from ram_data_out to any output except through the rsp_data register.

## Test plan
Bench configuration: NUM_REQ=2, DEPTH=16, DATA_WIDTH=8.
- Reset release, INIT_ZERO=1, preload RAM 0xFF -> ram_we_n low for 16 cycles with addresses 0..15 and data 0x00; init_done=1 at cycle 16; read of address 5 returns 0x00.
- Both writers held valid (req0 addr 3/0xA5, req1 addr 4/0x5A) for 4 cycles -> grants go 0,1,0,1; reads of 3 and 4 return 0xA5 and 0x5A.
- Same-cycle write 0x11 and read of address 7 (old value 0x00) -> rsp_data 0x00; a read in the next cycle -> 0x11.
- Both readers valid in cycle N (addresses 3, 4) -> rd_ready[0] in N with rsp_valid=01 in N+1; rd_ready[1] in N+1 with rsp_valid=10 in N+2.
- Reset pulsed at fill cycle 8 -> the fill restarts at address 0 and init_done rises 16 cycles after release. Reset in a read-grant cycle -> rsp_valid=0 next cycle.
- INIT_ZERO=0 -> init_done=1 and wr_ready available 1 cycle after reset release; no RAM writes occur while idle.
